// File: rtl/fp_add_dispatcher_pkg.sv
// Shared floating-point types for the adder front-end: IEEE single layout,
// result flags, operand pair and dispatcher state encoding.
package floatingpointpkg;

    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        logic [22:0] frac;
    } float_t;

    typedef struct packed {
        logic zero;
        logic inf;
        logic nan;
    } fp_flags_t;

    typedef struct packed {
        float_t a;
        float_t b;
    } operand_pair_t;

    typedef enum logic [1:0] {
        IDLE,
        GO,
        WAIT
    } dispatch_state_t;

endpackage

// File: rtl/fp_add_dispatcher_if.sv
// Operand stream, adder Go/Ready link and result slot of the dispatcher.
// master is the dispatcher's view; slave is the producer/adder/consumer side.
interface fp_add_dispatcher_if;
    import floatingpointpkg::*;

    logic      InValid;
    logic      InReady;
    float_t    InA;
    float_t    InB;
    float_t    AddA;
    float_t    AddB;
    logic      AddGo;
    logic      AddReady;
    float_t    AddResult;
    logic      AddZero;
    logic      AddInf;
    logic      AddNan;
    logic      OutValid;
    logic      OutReady;
    float_t    OutResult;
    fp_flags_t OutFlags;

    modport master (
        input  InValid, InA, InB, AddReady, AddResult, AddZero, AddInf, AddNan, OutReady,
        output InReady, AddA, AddB, AddGo, OutValid, OutResult, OutFlags
    );

    modport slave (
        output InValid, InA, InB, AddReady, AddResult, AddZero, AddInf, AddNan, OutReady,
        input  InReady, AddA, AddB, AddGo, OutValid, OutResult, OutFlags
    );

endinterface

// File: rtl/fp_add_dispatcher_operand_fifo.sv
// Small circular operand FIFO with a combinational head so the adder sees
// the oldest pair continuously until it is explicitly popped.
module fp_operand_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       push_data,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr_reg];
    assign count   = count_reg;

    always_ff @(posedge Clock) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers are exactly log2(DEPTH) wide, so they wrap on their own.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/fp_add_dispatcher.sv
// Issues buffered operand pairs to FloatingPointAdder one at a time, holds each
// result in a one-entry output slot and abandons ops the adder never finishes.
module fp_add_dispatcher
    import floatingpointpkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                Clock,
    input  logic                Reset,
    fp_add_dispatcher_if.master bus,
    output logic                Error,
    output logic [15:0]         OpCount
);
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int WD_W   = $clog2(TIMEOUT + 1);
    localparam int PAIR_W = $bits(operand_pair_t);

    dispatch_state_t   state_reg, state_next;
    logic [WD_W-1:0]   wd_reg, wd_next;
    logic              out_valid_reg, out_valid_next;
    float_t            out_result_reg, out_result_next;
    fp_flags_t         out_flags_reg, out_flags_next;
    logic              error_reg, error_next;
    logic [15:0]       op_count_reg, op_count_next;

    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [PAIR_W-1:0] head_bits;
    operand_pair_t     in_pair;
    operand_pair_t     head_pair;

    assign in_pair      = '{a: bus.InA, b: bus.InB};
    assign bus.InReady  = (fifo_count < CNT_W'(DEPTH));
    assign push         = bus.InValid && !fifo_full;
    assign head_pair    = operand_pair_t'(head_bits);

    fp_operand_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PAIR_W)
    ) u_fifo (
        .Clock     (Clock),
        .Reset     (Reset),
        .push      (push),
        .pop       (pop),
        .push_data (in_pair),
        .head      (head_bits),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Operands come straight from the head; it only moves once the op is done.
    assign bus.AddA      = head_pair.a;
    assign bus.AddB      = head_pair.b;
    assign bus.AddGo     = (state_reg == GO);
    assign bus.OutValid  = out_valid_reg;
    assign bus.OutResult = out_result_reg;
    assign bus.OutFlags  = out_flags_reg;
    assign Error         = error_reg;
    assign OpCount       = op_count_reg;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg      <= IDLE;
            wd_reg         <= '0;
            out_valid_reg  <= 1'b0;
            out_result_reg <= '0;
            out_flags_reg  <= '0;
            error_reg      <= 1'b0;
            op_count_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            wd_reg         <= wd_next;
            out_valid_reg  <= out_valid_next;
            out_result_reg <= out_result_next;
            out_flags_reg  <= out_flags_next;
            error_reg      <= error_next;
            op_count_reg   <= op_count_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        wd_next         = wd_reg;
        out_valid_next  = out_valid_reg;
        out_result_next = out_result_reg;
        out_flags_next  = out_flags_reg;
        error_next      = error_reg;
        op_count_next   = op_count_reg;
        pop             = 1'b0;

        if (out_valid_reg && bus.OutReady) begin
            out_valid_next = 1'b0;
        end

        case (state_reg)
            IDLE: begin
                if (!fifo_empty && !out_valid_reg) begin
                    state_next = GO;
                end
            end
            GO: begin
                wd_next    = '0;
                state_next = WAIT;
            end
            WAIT: begin
                wd_next = wd_reg + 1'b1;
                // Completion takes priority over a watchdog expiry in the same cycle.
                if (bus.AddReady) begin
                    out_result_next = bus.AddResult;
                    out_flags_next  = '{zero: bus.AddZero, inf: bus.AddInf, nan: bus.AddNan};
                    out_valid_next  = 1'b1;
                    op_count_next   = op_count_reg + 1'b1;
                    pop             = 1'b1;
                    state_next      = IDLE;
                end else if (wd_reg == WD_W'(TIMEOUT - 1)) begin
                    error_next = 1'b1;
                    pop        = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
